// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding,
// MUXAddressBus select values and grant identifiers.
package mem_bus_arbiter_pkg;

  // Arbiter FSM states (2-bit encoding shared with MemoryControl)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  // MUXAddressBus select: 1 = 8-bit fetch address, 0 = 16-bit data address
  localparam logic ADDR_SEL_FETCH = 1'b1;
  localparam logic ADDR_SEL_DATA  = 1'b0;

  // Requester that last won arbitration
  typedef enum logic {
    GRANT_DATA  = 1'b0,
    GRANT_FETCH = 1'b1
  } grant_e;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Per-transaction timeout counter.
// Ports: clk, rst_n (async active-low), clr (synchronous clear to 0),
//        en (count up), expire (registered, high while count == TIMEOUT-1).
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CTR_W = $clog2(TIMEOUT + 1);
  localparam logic [CTR_W-1:0] LAST = CTR_W'(TIMEOUT - 1);

  logic [CTR_W-1:0] cnt;

  // expire is computed from the next count so it is a flop, not a compare on the output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else if (clr) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else if (en) begin
      cnt    <= cnt + CTR_W'(1);
      expire <= ((cnt + CTR_W'(1)) == LAST);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// data access, with request/ready handshake and per-transaction timeout.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   f_req / f_ack / f_rdata         fetch requester handshake and read data
//   d_req / d_we / d_wdata          data requester request, direction, write data
//   d_ack / d_rdata                 data completion and read data
//   err                             timeout flag, valid with the ack
//   addr_sel                        MUXAddressBus select (1 fetch, 0 data)
//   mem_req / mem_we / mem_wdata    memory command
//   mem_rdata / mem_ready           memory response
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              addr_sel,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_e state_q, state_d;
  grant_e last_grant_q, last_grant_d;

  logic grant_fetch;
  logic ctr_clr, ctr_en, ctr_expire;
  logic mem_req_d, mem_we_d, addr_sel_d, f_ack_d, d_ack_d, err_d;
  logic [DATA_W-1:0] mem_wdata_d, f_rdata_d, d_rdata_d;

  // Fetch wins when alone, or on a tie when data was served last
  assign grant_fetch = f_req && (!d_req || (last_grant_q == GRANT_DATA));

  bus_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (ctr_clr),
    .en     (ctr_en),
    .expire (ctr_expire)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_DATA;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      addr_sel     <= 1'b0;
      f_ack        <= 1'b0;
      d_ack        <= 1'b0;
      err          <= 1'b0;
      f_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_req      <= mem_req_d;
      mem_we       <= mem_we_d;
      mem_wdata    <= mem_wdata_d;
      addr_sel     <= addr_sel_d;
      f_ack        <= f_ack_d;
      d_ack        <= d_ack_d;
      err          <= err_d;
      f_rdata      <= f_rdata_d;
      d_rdata      <= d_rdata_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req;
    mem_we_d     = mem_we;
    mem_wdata_d  = mem_wdata;
    addr_sel_d   = addr_sel;
    f_rdata_d    = f_rdata;
    d_rdata_d    = d_rdata;
    f_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    err_d        = 1'b0;
    ctr_clr      = 1'b0;
    ctr_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (f_req || d_req) begin
          mem_req_d = 1'b1;
          ctr_clr   = 1'b1;
          if (grant_fetch) begin
            state_d      = ST_FETCH;
            last_grant_d = GRANT_FETCH;
            addr_sel_d   = ADDR_SEL_FETCH;
            mem_we_d     = 1'b0;
          end else begin
            state_d      = ST_DATA;
            last_grant_d = GRANT_DATA;
            addr_sel_d   = ADDR_SEL_DATA;
            mem_we_d     = d_we;
            mem_wdata_d  = d_wdata;
          end
        end
      end

      ST_FETCH, ST_DATA: begin
        if (mem_ready) begin
          // Ready in the expire cycle still counts as success
          if (state_q == ST_FETCH) begin
            f_rdata_d = mem_rdata;
          end else if (!mem_we) begin
            d_rdata_d = mem_rdata;
          end
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          f_ack_d   = (state_q == ST_FETCH);
          d_ack_d   = (state_q == ST_DATA);
          state_d   = ST_ACK;
        end else if (ctr_expire) begin
          if (state_q == ST_FETCH) begin
            f_rdata_d = '0;
          end else begin
            d_rdata_d = '0;
          end
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          f_ack_d   = (state_q == ST_FETCH);
          d_ack_d   = (state_q == ST_DATA);
          err_d     = 1'b1;
          state_d   = ST_ACK;
        end else begin
          ctr_en = 1'b1;
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 15;

  logic              clk;
  logic              rst_n;
  logic              f_req;
  logic              f_ack;
  logic [DATA_W-1:0] f_rdata;
  logic              d_req;
  logic              d_we;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              err;
  logic              addr_sel;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  int errors = 0;
  int checks = 0;

  // memory responder controls
  int                ready_delay;
  logic [DATA_W-1:0] rd_val;
  int                req_cycles;

  // reference model: last served requester and expected read-data registers
  bit                m_last_f;
  logic [DATA_W-1:0] m_f_rd;
  logic [DATA_W-1:0] m_d_rd;

  mem_bus_arbiter #(
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .f_req    (f_req),
    .f_ack    (f_ack),
    .f_rdata  (f_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .err      (err),
    .addr_sel (addr_sel),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: raise ready in the ready_delay-th cycle of mem_req; data is only meaningful then
  initial begin
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    req_cycles = 0;
    forever begin
      @(negedge clk);
      if (mem_req && req_cycles == ready_delay) begin
        mem_ready = 1'b1;
        mem_rdata = rd_val;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
      if (mem_req) req_cycles++;
      else         req_cycles = 0;
    end
  end

  // Step until an ack is seen (bounded); report what the memory side looked like
  task automatic wait_ack(output bit got, output int cyc, output int nreq,
                          output logic sel, output bit stable, output logic we,
                          output logic [DATA_W-1:0] wd, output logic fa,
                          output logic da, output logic e);
    got = 0; cyc = 0; nreq = 0; sel = 1'b0; stable = 1; we = 1'b0; wd = '0;
    fa = 1'b0; da = 1'b0; e = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_req) begin
        if (nreq == 0) begin
          sel = addr_sel; we = mem_we; wd = mem_wdata;
        end else if (addr_sel !== sel || mem_we !== we || mem_wdata !== wd) begin
          stable = 0;
        end
        nreq++;
      end
      if (f_ack || d_ack) begin
        got = 1; fa = f_ack; da = d_ack; e = err;
      end
    end
  endtask

  task automatic do_reset(input logic fr, input logic dr);
    rst_n = 1'b0; f_req = fr; d_req = dr; d_we = 1'b0; d_wdata = '0;
    ready_delay = 0; rd_val = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_last_f = 0; m_f_rd = '0; m_d_rd = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      f_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom); d_wdata = $urandom;
      checks++;
      if ({f_ack, d_ack, err, addr_sel, mem_req, mem_we, f_rdata, d_rdata, mem_wdata} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: acks/err/sel/req/we=%b%b%b%b%b%b f_rdata=%h d_rdata=%h mem_wdata=%h, required all 0",
                 f_ack, d_ack, err, addr_sel, mem_req, mem_we, f_rdata, d_rdata, mem_wdata);
      end
    end
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    rst_n = 1'b1;
    m_last_f = 0; m_f_rd = '0; m_d_rd = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (mem_req !== 1'b0 || f_ack !== 1'b0 || d_ack !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset: mem_req=%b f_ack=%b d_ack=%b, required 0", mem_req, f_ack, d_ack);
      end
    end
  endtask

  task automatic test_single_fetch();
    bit got, stab; int cyc, nreq; logic sel, we, fa, da, e; logic [DATA_W-1:0] wd;
    rd_val = 32'hDEADBEEF; ready_delay = 2; f_req = 1'b1;
    wait_ack(got, cyc, nreq, sel, stab, we, wd, fa, da, e);
    f_req = 1'b0;
    checks++;
    if (!got || fa !== 1'b1 || da !== 1'b0) begin
      errors++; $display("FAIL fetch_ack: f_ack=%b d_ack=%b seen=%0d, required f_ack=1 d_ack=0", fa, da, got);
    end
    checks++;
    if (sel !== 1'b1 || we !== 1'b0 || !stab) begin
      errors++; $display("FAIL fetch_cmd: addr_sel=%b mem_we=%b stable=%0d, required 1 0 1", sel, we, stab);
    end
    checks++;
    if (nreq != 3 || cyc != 4) begin
      errors++; $display("FAIL fetch_timing: mem_req cycles=%0d ack after %0d, required 3 and 4", nreq, cyc);
    end
    checks++;
    if (f_rdata !== 32'hDEADBEEF || e !== 1'b0) begin
      errors++; $display("FAIL fetch_data: f_rdata=%h err=%b, required deadbeef 0", f_rdata, e);
    end
    @(posedge clk); #1;
    checks++;
    if (f_ack !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL fetch_ack_width: f_ack=%b err=%b one cycle later, required 0", f_ack, err);
    end
    m_last_f = 1; m_f_rd = 32'hDEADBEEF;
  endtask

  task automatic test_data_write();
    bit got, stab; int cyc, nreq; logic sel, we, fa, da, e; logic [DATA_W-1:0] wd;
    // a read first so the write has a non-zero d_rdata to preserve
    d_req = 1'b1; d_we = 1'b0; d_wdata = 32'h0; rd_val = 32'hA5A50F0F; ready_delay = 1;
    wait_ack(got, cyc, nreq, sel, stab, we, wd, fa, da, e);
    d_req = 1'b0;
    checks++;
    if (!got || da !== 1'b1 || sel !== 1'b0 || we !== 1'b0 || d_rdata !== 32'hA5A50F0F) begin
      errors++; $display("FAIL data_read: d_ack=%b addr_sel=%b mem_we=%b d_rdata=%h, required 1 0 0 a5a50f0f",
                         da, sel, we, d_rdata);
    end
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_wdata = 32'h12345678; rd_val = 32'hBAD0BAD0; ready_delay = 0;
    wait_ack(got, cyc, nreq, sel, stab, we, wd, fa, da, e);
    d_req = 1'b0; d_we = 1'b0;
    checks++;
    if (!got || da !== 1'b1 || fa !== 1'b0 || cyc != 2) begin
      errors++; $display("FAIL write_ack: d_ack=%b f_ack=%b after %0d cycles, required 1 0 after 2", da, fa, cyc);
    end
    checks++;
    if (sel !== 1'b0 || we !== 1'b1 || wd !== 32'h12345678 || !stab) begin
      errors++; $display("FAIL write_cmd: addr_sel=%b mem_we=%b mem_wdata=%h, required 0 1 12345678", sel, we, wd);
    end
    checks++;
    if (d_rdata !== 32'hA5A50F0F || f_rdata !== 32'hDEADBEEF || e !== 1'b0) begin
      errors++; $display("FAIL write_rdata: d_rdata=%h f_rdata=%h err=%b, required a5a50f0f deadbeef 0",
                         d_rdata, f_rdata, e);
    end
    @(posedge clk); #1;
    m_last_f = 0; m_d_rd = 32'hA5A50F0F;
  endtask

  task automatic test_timeout();
    bit got, stab; int cyc, nreq; logic sel, we, fa, da, e; logic [DATA_W-1:0] wd;
    f_req = 1'b1; rd_val = 32'h11112222; ready_delay = 1000;
    wait_ack(got, cyc, nreq, sel, stab, we, wd, fa, da, e);
    f_req = 1'b0;
    checks++;
    if (!got || fa !== 1'b1 || nreq != 15 || cyc != 16) begin
      errors++; $display("FAIL timeout_len: f_ack=%b mem_req cycles=%0d ack after %0d, required 1 15 16", fa, nreq, cyc);
    end
    checks++;
    if (e !== 1'b1 || f_rdata !== '0) begin
      errors++; $display("FAIL timeout_err: err=%b f_rdata=%h, required 1 0", e, f_rdata);
    end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0 || f_ack !== 1'b0) begin
      errors++; $display("FAIL timeout_err_width: err=%b f_ack=%b after ack, required 0", err, f_ack);
    end
    f_req = 1'b1; rd_val = 32'hCAFEF00D; ready_delay = 14;
    wait_ack(got, cyc, nreq, sel, stab, we, wd, fa, da, e);
    f_req = 1'b0;
    checks++;
    if (!got || fa !== 1'b1 || nreq != 15 || e !== 1'b0 || f_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL late_ready: f_ack=%b mem_req cycles=%0d err=%b f_rdata=%h, required 1 15 0 cafef00d",
                         fa, nreq, e, f_rdata);
    end
    @(posedge clk); #1;
    m_last_f = 1; m_f_rd = 32'hCAFEF00D;
  endtask

  task automatic test_contention();
    bit got, stab; int cyc, nreq; logic sel, we, fa, da, e; logic [DATA_W-1:0] wd;
    bit exp_f;
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      exp_f = (i % 2 == 0);
      ready_delay = int'($urandom_range(3, 0)); rd_val = $urandom;
      wait_ack(got, cyc, nreq, sel, stab, we, wd, fa, da, e);
      if (exp_f) m_f_rd = rd_val; else m_d_rd = rd_val;
      checks++;
      if (!got || fa !== exp_f || da !== !exp_f || sel !== exp_f) begin
        errors++; $display("FAIL contention_order[%0d]: f_ack=%b d_ack=%b addr_sel=%b, required f=%0d d=%0d",
                           i, fa, da, sel, exp_f, !exp_f);
      end
      checks++;
      if (f_rdata !== m_f_rd || d_rdata !== m_d_rd) begin
        errors++; $display("FAIL contention_data[%0d]: f_rdata=%h d_rdata=%h, required %h %h",
                           i, f_rdata, d_rdata, m_f_rd, m_d_rd);
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    m_last_f = 0;
  endtask

  task automatic test_back_to_back();
    bit got, stab; int cyc, nreq; logic sel, we, fa, da, e; logic [DATA_W-1:0] wd;
    d_req = 1'b1; d_we = 1'b0; ready_delay = 0;
    for (int i = 0; i < 3; i++) begin
      rd_val = $urandom;
      wait_ack(got, cyc, nreq, sel, stab, we, wd, fa, da, e);
      m_d_rd = rd_val;
      checks++;
      if (!got || da !== 1'b1 || cyc != ((i == 0) ? 2 : 3) || d_rdata !== m_d_rd) begin
        errors++; $display("FAIL back_to_back[%0d]: d_ack=%b after %0d cycles d_rdata=%h, required 1 after %0d %h",
                           i, da, cyc, d_rdata, (i == 0) ? 2 : 3, m_d_rd);
      end
    end
    d_req = 1'b0;
    @(posedge clk); #1;
    m_last_f = 0;
  endtask

  task automatic test_random();
    bit got, stab; int cyc, nreq; logic sel, we, fa, da, e; logic [DATA_W-1:0] wd;
    int dl_tab[10] = '{0, 1, 2, 3, 4, 5, 13, 14, 15, 40};
    bit pf, pd, exp_f, tmo;
    int exp_n;
    pf = 0; pd = 0;
    for (int i = 0; i < 40; i++) begin
      if (!pf) pf = 1'($urandom);
      if (!pd) begin
        pd = 1'($urandom);
        if (pd) begin d_we = 1'($urandom); d_wdata = $urandom; end
      end
      if (!pf && !pd) pf = 1;
      f_req = pf; d_req = pd;
      ready_delay = dl_tab[$urandom_range(9, 0)];
      rd_val = $urandom;
      exp_f = pf && (!pd || !m_last_f);
      tmo   = (ready_delay >= int'(TIMEOUT));
      exp_n = tmo ? int'(TIMEOUT) : ready_delay + 1;
      wait_ack(got, cyc, nreq, sel, stab, we, wd, fa, da, e);
      if (exp_f) m_f_rd = tmo ? '0 : rd_val;
      else if (tmo) m_d_rd = '0;
      else if (!d_we) m_d_rd = rd_val;
      checks++;
      if (!got || fa !== exp_f || da !== !exp_f || sel !== exp_f || !stab) begin
        errors++; $display("FAIL rand_grant[%0d]: f_ack=%b d_ack=%b addr_sel=%b, required grant fetch=%0d",
                           i, fa, da, sel, exp_f);
      end
      checks++;
      if (!exp_f && (we !== d_we || wd !== d_wdata)) begin
        errors++; $display("FAIL rand_cmd[%0d]: mem_we=%b mem_wdata=%h, required %b %h", i, we, wd, d_we, d_wdata);
      end
      checks++;
      if (nreq != exp_n || cyc != exp_n + 1 || e !== tmo) begin
        errors++; $display("FAIL rand_timing[%0d]: mem_req cycles=%0d ack after %0d err=%b, required %0d %0d %0d",
                           i, nreq, cyc, e, exp_n, exp_n + 1, tmo);
      end
      checks++;
      if (f_rdata !== m_f_rd || d_rdata !== m_d_rd) begin
        errors++; $display("FAIL rand_rdata[%0d]: f_rdata=%h d_rdata=%h, required %h %h",
                           i, f_rdata, d_rdata, m_f_rd, m_d_rd);
      end
      m_last_f = exp_f;
      if (exp_f) pf = 0; else pd = 0;
      f_req = pf; d_req = pd;
      @(posedge clk); #1;
      checks++;
      if (f_ack !== 1'b0 || d_ack !== 1'b0 || err !== 1'b0) begin
        errors++; $display("FAIL rand_ack_width[%0d]: f_ack=%b d_ack=%b err=%b after ack, required 0", i, f_ack, d_ack, err);
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_data();
    bit got, stab; int cyc, nreq; logic sel, we, fa, da, e; logic [DATA_W-1:0] wd;
    bit saw_ack;
    d_req = 1'b1; d_we = 1'($urandom); d_wdata = $urandom; ready_delay = 1000;
    @(posedge clk); #1;
    checks++;
    if (mem_req !== 1'b1 || addr_sel !== 1'b0) begin
      errors++; $display("FAIL pre_abort: mem_req=%b addr_sel=%b, required 1 0", mem_req, addr_sel);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || d_ack !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL async_abort: mem_req=%b d_ack=%b err=%b, required 0", mem_req, d_ack, err);
    end
    saw_ack = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (d_ack || f_ack || mem_req) saw_ack = 1;
    end
    checks++;
    if (saw_ack) begin
      errors++; $display("FAIL abort_no_ack: ack or mem_req seen=1 during reset, required 0");
    end
    m_last_f = 0; m_f_rd = '0; m_d_rd = '0;
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; ready_delay = 0; rd_val = 32'h0F0F1234;
    rst_n = 1'b1;
    wait_ack(got, cyc, nreq, sel, stab, we, wd, fa, da, e);
    f_req = 1'b0;
    checks++;
    if (!got || fa !== 1'b1 || da !== 1'b0 || f_rdata !== 32'h0F0F1234 || d_rdata !== '0) begin
      errors++; $display("FAIL post_reset_tie: f_ack=%b d_ack=%b f_rdata=%h d_rdata=%h, required 1 0 0f0f1234 0",
                         fa, da, f_rdata, d_rdata);
    end
    rd_val = 32'h55AA55AA;
    wait_ack(got, cyc, nreq, sel, stab, we, wd, fa, da, e);
    d_req = 1'b0;
    checks++;
    if (!got || da !== 1'b1 || d_rdata !== 32'h55AA55AA) begin
      errors++; $display("FAIL post_reset_data: d_ack=%b d_rdata=%h, required 1 55aa55aa", da, d_rdata);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    ready_delay = 0; rd_val = '0;
    m_last_f = 0; m_f_rd = '0; m_d_rd = '0;
    test_reset();
    test_single_fetch();
    test_data_write();
    test_timeout();
    test_contention();
    test_back_to_back();
    test_random();
    test_reset_mid_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 time units");
    $fatal(1, "watchdog");
  end

endmodule
